control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL provide parameter: RESET_PC, 8'h00, program counter value loaded on reset.
REQ-002 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: imem_addr  output  8  instruction address (equals PC).
REQ-005 SHALL have port: imem_data  input  16  instruction word, valid one cycle after imem_addr (synchronous ROM).
REQ-006 SHALL have ports: dmem_addr output 8; dmem_we output 1; dmem_wdata output 8; data RAM address, write strobe and write data (RAM read data returns to datapath one cycle later).
REQ-007 SHALL have ports: read_a, read_b input 8; alu_zero, alu_carry input 1; forwarded register operands and ALU flags from the datapath.
REQ-008 SHALL have ports: alu_opcode output 3; write_alu, is_load, alu_imm_flag, write_en output 1; write_addr, ra_addr, rb_addr output 4; imm_data output 8; datapath controls.
REQ-009 SHALL have port: halted  output  1  high once HALT has executed.

Function
REQ-010 Instruction fields SHALL be op=[15:12], rd=[11:8], ra=[7:4], rb=[3:0], imm=[7:0].
REQ-011 FSM SHALL have states FETCH, EXEC, LOAD, HALT; FETCH->EXEC always; EXEC->LOAD for LD, ->HALT for HALT, else ->FETCH; LOAD->FETCH; HALT->HALT.
REQ-012 Latency: LD three cycles, HALT two cycles then frozen, all other instructions two cycles.
REQ-013 In EXEC, controls SHALL decode from imem_data combinationally; imem_data SHALL also be captured into an instruction register for use in LOAD.
REQ-014 op 0x0-0x7 (ALU): alu_opcode=op[2:0], write_alu=1, ra_addr=ra, rb_addr=rb, write_addr=rd, write_en=1.
REQ-015 op 0x8 (LI): write_alu=0, is_load=0, imm_data=imm, write_addr=rd, write_en=1.
REQ-016 op 0x9 (ADDI): ra_addr=rd, alu_imm_flag=1, alu_opcode=3'b000, imm_data=imm, write_alu=1, write_addr=rd, write_en=1.
REQ-017 op 0xA (LD): EXEC drives ra_addr=ra, dmem_addr=read_a, dmem_we=0; LOAD drives is_load=1, write_addr=captured rd, write_en=1.
REQ-018 op 0xB (ST): ra_addr=ra, rb_addr=rb, dmem_addr=read_a, dmem_wdata=read_b, dmem_we=1 for exactly the EXEC cycle; write_en=0.
REQ-019 op 0xC JMP, 0xD BZ, 0xE BC: PC<=imm if JMP, or BZ with Z flag=1, or BC with C flag=1; otherwise PC<=PC+1.
REQ-020 op 0xF (HALT): enter HALT, halted=1, PC not incremented.
REQ-021 Z/C flag registers SHALL capture alu_zero/alu_carry at the end of EXEC for ALU and ADDI only; all other instructions leave them unchanged.
REQ-022 PC SHALL advance by 1 at the end of EXEC for non-branching instructions, wrapping 8'hFF->8'h00.
REQ-023 write_en SHALL be forced 0 whenever the destination register is 0.
REQ-024 Outside EXEC/LOAD, write_en, dmem_we, write_alu, is_load, alu_imm_flag SHALL be 0.
REQ-025 In HALT, PC, flags and all controls SHALL be frozen and inactive until reset.

Reset
REQ-026 rst_n low SHALL asynchronously set state=FETCH, PC=RESET_PC, flags=0, instruction register=0, halted=0, all control outputs 0.
REQ-027 Reset asserted mid-LD (EXEC or LOAD) SHALL abort the instruction with no register write.
REQ-028 First fetch after rst_n deasserts SHALL address RESET_PC.

Configuration
REQ-029 Macro CU_CARRY_BRANCH_EN defined: op 0xE executes as BC per REQ-019.
REQ-030 Macro CU_CARRY_BRANCH_EN undefined: op 0xE SHALL execute as a NOP (PC+1, no writes, no flag change), and the C flag register SHALL NOT be implemented.

Verification
REQ-031 Reset, then program LI r1,0x05; LI r2,0x03; ALU(op0) r3,r1,r2 -> write_en pulses at cycles 2,4,6, write_addr 1,2,3, alu_opcode=0 on third.
REQ-032 ST [r1],r2 with r1=0x10, r2=0xAA -> one cycle dmem_we=1, dmem_addr=0x10, dmem_wdata=0xAA, write_en=0.
REQ-033 LD r4,[r1] with r1=0x10 -> EXEC dmem_addr=0x10; next cycle is_load=1, write_addr=4, write_en=1; next fetch at PC+1.
REQ-034 ALU result zero then BZ 0x40 -> imem_addr=0x40 on next fetch; with Z=0 -> PC+1.
REQ-035 PC=0xFF, LI r1,0x01 -> next imem_addr=0x00; HALT -> halted=1, imem_addr frozen, write_en=0 for 20 cycles.
REQ-036 rst_n low during LOAD of LD r5 -> write_en=0, PC=RESET_PC; BC with C=1 branches only when CU_CARRY_BRANCH_EN defined.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/EXEC/LOAD/HALT sequencing, decode and PC/flag management.
// Optional macro CU_CARRY_BRANCH_EN enables the BC instruction and the carry flag register.
module control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  output logic [7:0]  dmem_addr,
  output logic        dmem_we,
  output logic [7:0]  dmem_wdata,
  input  logic [7:0]  read_a,
  input  logic [7:0]  read_b,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic [2:0]  alu_opcode,
  output logic        write_alu,
  output logic        is_load,
  output logic        alu_imm_flag,
  output logic        write_en,
  output logic [3:0]  write_addr,
  output logic [3:0]  ra_addr,
  output logic [3:0]  rb_addr,
  output logic [7:0]  imm_data,
  output logic        halted
);

  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;
`ifdef CU_CARRY_BRANCH_EN
  localparam logic [3:0] OP_BC   = 4'hE;
`endif

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD, S_HALT} state_t;

  state_t      r_state, w_next_state;
  logic [7:0]  r_pc, w_next_pc;
  logic        r_z, w_next_z;
  logic [15:0] r_ir;
  logic        w_we;

  logic [3:0]  w_op, w_rd, w_ra, w_rb;
  logic [7:0]  w_imm;

  assign w_op  = imem_data[15:12];
  assign w_rd  = imem_data[11:8];
  assign w_ra  = imem_data[7:4];
  assign w_rb  = imem_data[3:0];
  assign w_imm = imem_data[7:0];

  assign imem_addr = r_pc;
  assign halted    = (r_state == S_HALT);

`ifdef CU_CARRY_BRANCH_EN
  logic r_c, w_next_c;
  logic w_unused;
  assign w_unused = ^{r_ir[15:12], r_ir[7:0]};
`else
  logic w_unused;
  assign w_unused = ^{r_ir[15:12], r_ir[7:0], alu_carry};
`endif

  // State, PC, flags and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_z     <= 1'b0;
      r_ir    <= 16'h0000;
`ifdef CU_CARRY_BRANCH_EN
      r_c     <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_z     <= w_next_z;
`ifdef CU_CARRY_BRANCH_EN
      r_c     <= w_next_c;
`endif
      if (r_state == S_EXEC) r_ir <= imem_data;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_z     = r_z;
`ifdef CU_CARRY_BRANCH_EN
    w_next_c     = r_c;
`endif
    alu_opcode   = 3'b000;
    write_alu    = 1'b0;
    is_load      = 1'b0;
    alu_imm_flag = 1'b0;
    w_we         = 1'b0;
    write_addr   = 4'h0;
    ra_addr      = 4'h0;
    rb_addr      = 4'h0;
    imm_data     = 8'h00;
    dmem_addr    = 8'h00;
    dmem_we      = 1'b0;
    dmem_wdata   = 8'h00;

    case (r_state)
      S_FETCH: w_next_state = S_EXEC;
      S_EXEC: begin
        w_next_state = S_FETCH;
        w_next_pc    = 8'(r_pc + 8'd1);
        if (!w_op[3]) begin
          alu_opcode = w_op[2:0];
          write_alu  = 1'b1;
          ra_addr    = w_ra;
          rb_addr    = w_rb;
          write_addr = w_rd;
          w_we       = 1'b1;
          w_next_z   = alu_zero;
`ifdef CU_CARRY_BRANCH_EN
          w_next_c   = alu_carry;
`endif
        end else begin
          case (w_op)
            OP_LI: begin
              imm_data   = w_imm;
              write_addr = w_rd;
              w_we       = 1'b1;
            end
            OP_ADDI: begin
              ra_addr      = w_rd;
              alu_imm_flag = 1'b1;
              imm_data     = w_imm;
              write_alu    = 1'b1;
              write_addr   = w_rd;
              w_we         = 1'b1;
              w_next_z     = alu_zero;
`ifdef CU_CARRY_BRANCH_EN
              w_next_c     = alu_carry;
`endif
            end
            OP_LD: begin
              w_next_state = S_LOAD;
              ra_addr      = w_ra;
              dmem_addr    = read_a;
            end
            OP_ST: begin
              ra_addr    = w_ra;
              rb_addr    = w_rb;
              dmem_addr  = read_a;
              dmem_wdata = read_b;
              dmem_we    = 1'b1;
            end
            OP_JMP: w_next_pc = w_imm;
            OP_BZ:  if (r_z) w_next_pc = w_imm;
`ifdef CU_CARRY_BRANCH_EN
            OP_BC:  if (r_c) w_next_pc = w_imm;
`endif
            OP_HALT: begin
              w_next_state = S_HALT;
              w_next_pc    = r_pc;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        w_next_state = S_FETCH;
        is_load      = 1'b1;
        write_addr   = r_ir[11:8];
        w_we         = 1'b1;
      end
      default: ;
    endcase

    // r0 is hardwired: never write it
    write_en = w_we && (write_addr != 4'h0);
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit with a synchronous ROM model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_wdata;
  logic [7:0]  read_a;
  logic [7:0]  read_b;
  logic        alu_zero;
  logic        alu_carry;
  logic [2:0]  alu_opcode;
  logic        write_alu;
  logic        is_load;
  logic        alu_imm_flag;
  logic        write_en;
  logic [3:0]  write_addr;
  logic [3:0]  ra_addr;
  logic [3:0]  rb_addr;
  logic [7:0]  imm_data;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [256];

  control_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .read_a(read_a), .read_b(read_b),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_opcode(alu_opcode), .write_alu(write_alu), .is_load(is_load),
    .alu_imm_flag(alu_imm_flag), .write_en(write_en),
    .write_addr(write_addr), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .imm_data(imm_data), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  logic [7:0] exp_bc;

  initial begin
    rst_n     = 1'b0;
    read_a    = 8'h10;
    read_b    = 8'hAA;
    alu_zero  = 1'b1;
    alu_carry = 1'b0;
`ifdef CU_CARRY_BRANCH_EN
    exp_bc = 8'h20;
`else
    exp_bc = 8'h47;
`endif

    // Program A
    fill_rom();
    rom[8'h00] = 16'h8105;  // LI r1,0x05
    rom[8'h01] = 16'h8203;  // LI r2,0x03
    rom[8'h02] = 16'h0312;  // ADD r3,r1,r2
    rom[8'h03] = 16'hD040;  // BZ 0x40
    rom[8'h40] = 16'h1456;  // ALU op1 r4,r5,r6
    rom[8'h41] = 16'hD080;  // BZ 0x80
    rom[8'h42] = 16'hB012;  // ST [r1],r2
    rom[8'h43] = 16'hA410;  // LD r4,[r1]
    rom[8'h44] = 16'h8077;  // LI r0,0x77
    rom[8'h45] = 16'h9610;  // ADDI r6,0x10
    rom[8'h46] = 16'hE020;  // BC 0x20
    rom[8'h47] = 16'hC0FF;  // JMP 0xFF
    rom[8'h20] = 16'hC0FF;  // JMP 0xFF
    rom[8'hFF] = 16'h8101;  // LI r1,0x01

    repeat (2) tick();
    check("reset_state", {halted, write_en, dmem_we, is_load, write_alu, alu_imm_flag, imem_addr},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
    check("fetch0", {24'h0, imem_addr}, 32'h00);
    tick();
    check("li_r1", {write_en, write_addr, imm_data, write_alu, is_load}, {1'b1, 4'd1, 8'h05, 1'b0, 1'b0});
    tick(); check("fetch1", {24'h0, imem_addr}, 32'h01);
    tick();
    check("li_r2", {write_en, write_addr, imm_data}, {1'b1, 4'd2, 8'h03});
    tick(); check("fetch2", {24'h0, imem_addr}, 32'h02);
    tick();
    check("alu_add", {write_en, write_addr, alu_opcode, write_alu, ra_addr, rb_addr},
          {1'b1, 4'd3, 3'd0, 1'b1, 4'd1, 4'd2});
    tick(); alu_zero = 1'b0;
    check("fetch_write_idle", {write_en, write_alu, imem_addr}, {1'b0, 1'b0, 8'h03});
    tick(); check("bz_exec", {30'h0, write_en, dmem_we}, 32'h0);
    tick(); check("bz_taken", {24'h0, imem_addr}, 32'h40);
    tick();
    check("alu_op1", {write_en, write_addr, alu_opcode}, {1'b1, 4'd4, 3'd1});
    tick(); check("fetch41", {24'h0, imem_addr}, 32'h41);
    tick();
    tick(); check("bz_not_taken", {24'h0, imem_addr}, 32'h42);
    tick();
    check("st_exec", {dmem_we, dmem_addr, dmem_wdata, write_en, ra_addr, rb_addr},
          {1'b1, 8'h10, 8'hAA, 1'b0, 4'd1, 4'd2});
    tick();
    check("st_done", {dmem_we, imem_addr}, {1'b0, 8'h43});
    tick();
    check("ld_exec", {dmem_addr, dmem_we, write_en, is_load, ra_addr}, {8'h10, 1'b0, 1'b0, 1'b0, 4'd1});
    tick();
    check("ld_load", {is_load, write_addr, write_en}, {1'b1, 4'd4, 1'b1});
    tick();
    check("ld_next_fetch", {is_load, write_en, imem_addr}, {1'b0, 1'b0, 8'h44});
    tick();
    check("li_r0_gated", {write_en, write_addr, imm_data}, {1'b0, 4'd0, 8'h77});
    tick(); alu_carry = 1'b1;
    check("fetch45", {24'h0, imem_addr}, 32'h45);
    tick();
    check("addi", {alu_imm_flag, ra_addr, imm_data, alu_opcode, write_alu, write_addr, write_en},
          {1'b1, 4'd6, 8'h10, 3'd0, 1'b1, 4'd6, 1'b1});
    tick(); alu_carry = 1'b0;
    tick(); check("bc_exec", {31'h0, write_en}, 32'h0);
    tick(); check("bc_target", {24'h0, imem_addr}, {24'h0, exp_bc});
    tick();
    tick(); check("jmp_ff", {24'h0, imem_addr}, 32'hFF);
    tick(); check("li_at_ff", {write_en, write_addr}, {1'b1, 4'd1});
    tick(); check("pc_wrap", {24'h0, imem_addr}, 32'h00);

    // Program B: reset in LOAD, then HALT freeze
    rst_n = 1'b0;
    fill_rom();
    rom[8'h00] = 16'hA510;  // LD r5,[r1]
    rom[8'h01] = 16'hF000;  // HALT
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("ld5_load", {is_load, write_addr, write_en}, {1'b1, 4'd5, 1'b1});
    #1 rst_n = 1'b0;
    #1 check("reset_in_load", {write_en, is_load, imem_addr}, {1'b0, 1'b0, 8'h00});
    tick(); rst_n = 1'b1;
    check("refetch0", {24'h0, imem_addr}, 32'h00);
    tick(); tick(); tick();
    check("fetch_halt", {halted, imem_addr}, {1'b0, 8'h01});
    tick();
    check("halt_exec", {halted, write_en}, {1'b0, 1'b0});
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halt_frozen", {halted, write_en, dmem_we, is_load, imem_addr},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h01});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
